// File: rtl/giaima_pkg.sv
// Shared constants, state encoding and decode helper for the scan selector.
package giaima_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    // One-hot (or one-cold) decode of idx into the low 2**n bits; upper bits stay 0.
    function automatic logic [63:0] decode_1hot(input logic [5:0] idx,
                                                 input int unsigned n,
                                                 input logic act_low);
        logic [63:0] one;
        logic [63:0] mask;
        one  = 64'(1) << idx;
        mask = (n >= 6) ? {64{1'b1}} : ((64'(1) << (1 << n)) - 64'(1));
        return act_low ? (~one & mask) : one;
    endfunction

endpackage

// File: rtl/giaima_dwell_cnt.sv
// Dwell counter: counts RUN cycles modulo DWELL, TC marks the last cycle of a dwell.
module giaima_dwell_cnt #(
    parameter int unsigned DWELL = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    input  logic RUN,
    output logic TC
);
    localparam int unsigned CW = $clog2(DWELL + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign TC = (cnt_q == CW'(DWELL - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (CLR) begin
            cnt_d = '0;
        end else if (RUN) begin
            cnt_d = TC ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/giaima_scan_sel.sv
// N-to-2^N registered decoder with enable and auto-scan (dwell-timed stepping).
module giaima_scan_sel
    import giaima_pkg::*;
#(
    parameter int unsigned N       = 3,
    parameter int unsigned DWELL   = 4,
    parameter bit          ACT_LOW = 1'b0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               MODE,
    input  logic               LOAD,
    input  logic [N-1:0]       I,
    output logic [(2**N)-1:0]  O,
    output logic [N-1:0]       IDX,
    output logic               WRAP
);
    localparam int unsigned W = 2**N;

    state_e         state_q, state_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [W-1:0]   o_q, o_d;
    logic           wrap_q, wrap_d;
    logic           cnt_clr, cnt_run, cnt_tc;

    giaima_dwell_cnt #(.DWELL(DWELL)) u_dwell (
        .CLK (CLK),
        .RST (RST),
        .CLR (cnt_clr),
        .RUN (cnt_run),
        .TC  (cnt_tc)
    );

    // The action at each edge follows the EN/MODE sampled at that edge.
    always_comb begin
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_run = 1'b0;
        o_d     = {W{ACT_LOW}};

        if (!EN) begin
            state_d = ST_OFF;
        end else if (MODE == MODE_SCAN) begin
            state_d = ST_SCAN;
        end else begin
            state_d = ST_DIRECT;
        end

        case (state_d)
            ST_DIRECT: begin
                idx_d   = I;
                cnt_clr = 1'b1;
            end
            ST_SCAN: begin
                if (LOAD) begin
                    idx_d   = I;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_run = 1'b1;
                    if (cnt_tc) begin
                        idx_d  = idx_q + N'(1);
                        wrap_d = (idx_q == {N{1'b1}});
                    end
                end
            end
            default: ;
        endcase

        if (state_d != ST_OFF) begin
            o_d = W'(decode_1hot(6'(idx_d), N, ACT_LOW));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_OFF;
            idx_q   <= '0;
            o_q     <= {W{ACT_LOW}};
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            o_q     <= o_d;
            wrap_q  <= wrap_d;
        end
    end

    assign O    = o_q;
    assign IDX  = idx_q;
    assign WRAP = wrap_q;

    // Whenever the block is on, exactly one output line is active.
    assert property (@(posedge CLK) (state_q != ST_OFF) |-> $onehot(o_q ^ {W{ACT_LOW}}));

endmodule

// File: tb/tb_giaima_scan_sel.sv
// Scoreboard bench: directed stimulus pushes hand-computed expectations, a monitor checks them.
module tb_giaima_scan_sel;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic       load;
    logic [2:0] i_sel;
    logic [7:0] o_hi, o_lo;
    logic [2:0] idx_hi, idx_lo;
    logic       wrap_hi, wrap_lo;

    int tests_run = 0;
    int tests_failed = 0;

    // Expected entry: {O (active-high build), IDX, WRAP}
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    giaima_scan_sel #(.N(3), .DWELL(4), .ACT_LOW(1'b0)) dut_hi (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .LOAD(load), .I(i_sel),
        .O(o_hi), .IDX(idx_hi), .WRAP(wrap_hi)
    );

    giaima_scan_sel #(.N(3), .DWELL(4), .ACT_LOW(1'b1)) dut_lo (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .LOAD(load), .I(i_sel),
        .O(o_lo), .IDX(idx_lo), .WRAP(wrap_lo)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expected entry is consumed per clock edge.
    always @(posedge clk) begin
        logic [11:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("O",        o_hi,            e[11:4]);
            check("IDX",      8'(idx_hi),      8'(e[3:1]));
            check("WRAP",     8'(wrap_hi),     8'(e[0]));
            check("O_actlow", o_lo,            ~e[11:4]);
            check("IDX_actlow", 8'(idx_lo),    8'(e[3:1]));
            check("WRAP_actlow", 8'(wrap_lo),  8'(e[0]));
        end
    end

    task automatic cyc(input logic r, input logic e_n, input logic md, input logic ld,
                       input logic [2:0] sel,
                       input logic [7:0] eo, input logic [2:0] ei, input logic ew);
        @(negedge clk);
        rst   = r;
        en    = e_n;
        mode  = md;
        load  = ld;
        i_sel = sel;
        exp_q.push_back({eo, ei, ew});
    endtask

    task automatic scan_n(input int n, input logic [7:0] eo, input logic [2:0] ei);
        for (int k = 0; k < n; k++) cyc(0, 1, 1, 0, 3'd0, eo, ei, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; i_sel = 3'd0;

        cyc(1, 1, 1, 1, 3'd5, 8'h00, 3'd0, 1'b0);
        cyc(1, 0, 0, 0, 3'd2, 8'h00, 3'd0, 1'b0);

        // Direct decode of every select value
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, 0, 0, 3'(k), 8'(1 << k), 3'(k), 1'b0);
        end

        // Disabled: outputs inactive, index held
        cyc(0, 0, 1, 0, 3'd5, 8'h00, 3'd7, 1'b0);
        cyc(0, 0, 0, 1, 3'd2, 8'h00, 3'd7, 1'b0);

        // Scan from 6 with wrap: direct load counts as the first dwell cycle
        cyc(0, 1, 0, 0, 3'd6, 8'h40, 3'd6, 1'b0);
        scan_n(3, 8'h40, 3'd6);
        scan_n(4, 8'h80, 3'd7);
        cyc(0, 1, 1, 0, 3'd0, 8'h01, 3'd0, 1'b1);
        scan_n(2, 8'h01, 3'd0);

        // Dwell count now 2: freeze for 5 cycles, then finish remaining dwell
        for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0, 3'd4, 8'h00, 3'd0, 1'b0);
        scan_n(1, 8'h01, 3'd0);
        scan_n(2, 8'h02, 3'd1);

        // LOAD mid-dwell restarts a full dwell at the loaded index
        cyc(0, 1, 1, 1, 3'd3, 8'h08, 3'd3, 1'b0);
        scan_n(3, 8'h08, 3'd3);
        scan_n(1, 8'h10, 3'd4);

        // SCAN -> DIRECT discards partial dwell; back to SCAN gives full dwell
        cyc(0, 1, 0, 0, 3'd2, 8'h04, 3'd2, 1'b0);
        scan_n(3, 8'h04, 3'd2);
        scan_n(1, 8'h08, 3'd3);

        // LOAD of the last index, then wrap
        cyc(0, 1, 1, 1, 3'd7, 8'h80, 3'd7, 1'b0);
        scan_n(3, 8'h80, 3'd7);
        cyc(0, 1, 1, 0, 3'd0, 8'h01, 3'd0, 1'b1);

        // Reset mid-scan overrides everything; scan restarts at 0 with full dwell
        scan_n(1, 8'h01, 3'd0);
        cyc(1, 1, 1, 1, 3'd5, 8'h00, 3'd0, 1'b0);
        scan_n(3, 8'h01, 3'd0);
        scan_n(1, 8'h02, 3'd1);

        @(posedge clk);
        #3;
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete, %0d failed so far", tests_failed);
        $fatal(1);
    end

endmodule
